// File: rtl/fpaddsub_align_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_align_pkg
// Purpose  : Shared widths, slice helper and beat type for the align shifter.
// Revision : 1.0
// ============================================================================
package fpaddsub_align_pkg;

    localparam int ALIGN_MAX_MAN_W = 23;
    localparam int ALIGN_MAX_EXT_W = ALIGN_MAX_MAN_W + 3;

    // Width of one per-stage slice of the shift amount: ceil(shift_w / stages).
    function automatic int slice_width(input int shift_w, input int stages);
        return (shift_w + stages - 1) / stages;
    endfunction

    localparam int ALIGN_EXT_W   = ALIGN_MAX_EXT_W;
    localparam int ALIGN_SLICE_W = slice_width(5, 2);

    // The mantissa field is sized for the widest format; narrower formats sit
    // zero-extended in its low bits.
    typedef struct packed {
        logic [ALIGN_MAX_EXT_W-1:0] mant;
        logic                       sticky;
    } align_beat_t;

endpackage
`default_nettype wire

// File: rtl/fpaddsub_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_align_stage
// Purpose  : One registered align stage: shifts by its weighted slice of the
//            shift amount, folds dropped bits into sticky, owns one slot.
// Revision : 1.0
// ============================================================================
module fpaddsub_align_stage
    import fpaddsub_align_pkg::*;
#(
    parameter int PAD_W     = 6,
    parameter int SLICE_W   = 3,
    parameter int SLICE_LSB = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  align_beat_t      i_beat,
    input  logic [PAD_W-1:0] i_shift,
    input  logic             i_ready,
    output logic             o_valid,
    output align_beat_t      o_beat,
    output logic [PAD_W-1:0] o_shift
);

    logic [SLICE_W-1:0]         w_slice;
    logic [PAD_W-1:0]           w_amt;
    logic [ALIGN_MAX_EXT_W-1:0] w_lost_mask;
    align_beat_t                w_next;
    logic                       w_load;

    logic                       r_valid;
    align_beat_t                r_beat;
    logic [PAD_W-1:0]           r_shift;

    assign w_slice     = i_shift[SLICE_LSB +: SLICE_W];
    assign w_amt       = PAD_W'(w_slice) << SLICE_LSB;
    // Amounts at or beyond the container width yield an all-ones mask.
    assign w_lost_mask = ~({ALIGN_MAX_EXT_W{1'b1}} << w_amt);

    always_comb begin
        w_next.mant   = i_beat.mant >> w_amt;
        w_next.sticky = i_beat.sticky | (|(i_beat.mant & w_lost_mask));
    end

    assign w_load = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_shift <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_beat  <= w_next;
                r_shift <= i_shift;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_beat  = r_beat;
    assign o_shift = r_shift;

endmodule
`default_nettype wire

// File: rtl/fpaddsub_align_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_align_shift_pipe
// Purpose  : Valid/ready pipelined alignment shifter with guard/round/sticky.
//            Option macro FPADDSUB_ALIGN_DENORM_EN adds the m_hidden input.
// Revision : 1.0
// ============================================================================
module fpaddsub_align_shift_pipe
    import fpaddsub_align_pkg::*;
#(
    parameter int MAN_W   = 23,
    parameter int SHIFT_W = 5,
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W-1:0]   m_min,
`ifdef FPADDSUB_ALIGN_DENORM_EN
    input  logic               m_hidden,
`endif
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W:0]     m_aligned,
    output logic               guard,
    output logic               round,
    output logic               sticky
);

    localparam int EXT_W   = MAN_W + 3;
    localparam int SLICE_W = slice_width(SHIFT_W, STAGES);
    localparam int PAD_W   = SLICE_W * STAGES;

    logic             w_hidden;
    logic [EXT_W-1:0] w_ext;
    logic             w_sat;
    align_beat_t      w_beat_in;
    logic [PAD_W-1:0] w_shift_in;
    logic [STAGES:0]  w_vld;
    logic [STAGES:0]  w_rdy;
    align_beat_t      w_beat  [0:STAGES];
    logic [PAD_W-1:0] w_shift [0:STAGES];
    logic [PAD_W-1:0] w_unused_shift;

`ifdef FPADDSUB_ALIGN_DENORM_EN
    assign w_hidden = m_hidden;
`else
    assign w_hidden = 1'b1;
`endif

    assign w_ext = {w_hidden, m_min, 2'b00};
    assign w_sat = (int'(shift) >= EXT_W);

    // Saturated beats enter with the whole significand already collapsed into
    // sticky and a zero shift, so the stages pass them through unchanged.
    always_comb begin
        w_beat_in.mant   = w_sat ? '0 : ALIGN_MAX_EXT_W'(w_ext);
        w_beat_in.sticky = w_sat & (|{w_hidden, m_min});
        w_shift_in       = w_sat ? '0 : PAD_W'(shift);
    end

    assign w_beat[0]  = w_beat_in;
    assign w_shift[0] = w_shift_in;
    assign w_vld[0]   = in_valid;

    // Stage k is loadable when it or any stage downstream has a free slot,
    // or the consumer is taking the head beat this cycle.
    always_comb begin
        w_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = !w_vld[k+1] || w_rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fpaddsub_align_stage #(
            .PAD_W     (PAD_W),
            .SLICE_W   (SLICE_W),
            .SLICE_LSB (SLICE_W * (STAGES - 1 - k))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_vld[k]),
            .i_beat  (w_beat[k]),
            .i_shift (w_shift[k]),
            .i_ready (w_rdy[k+1]),
            .o_valid (w_vld[k+1]),
            .o_beat  (w_beat[k+1]),
            .o_shift (w_shift[k+1])
        );
    end

    assign w_unused_shift = w_shift[STAGES];

    assign in_ready  = w_rdy[0];
    assign out_valid = w_vld[STAGES];
    assign m_aligned = w_beat[STAGES].mant[EXT_W-1:2];
    assign guard     = w_beat[STAGES].mant[1];
    assign round     = w_beat[STAGES].mant[0];
    assign sticky    = w_beat[STAGES].sticky;

endmodule
`default_nettype wire
